// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Responder end of the core's load/store data-memory interface. One
// word-addressed read or write is accepted at a time on a valid/ready request
// channel. After WAIT_CYCLES wait states the access is performed on a local
// word array. The read data and an out-of-range error flag are then returned
// on a valid/ready response channel.
//
// Parameters
//   DEPTH        number of 32-bit words in the array (must equal 2**AW)
//   AW           word index width
//   WAIT_CYCLES  wait states between accept and access, 0..15
//
// Ports
//   clk        in   rising-edge clock
//   RN         in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  responder can accept a request (registered)
//   req_we     in   1 = write, 0 = read
//   req_addr   in   word address (not a byte address)
//   req_wdata  in   write data
//   req_wstrb  in   byte enables, bit i enables byte [8i+7:8i]
//   rsp_valid  out  response present
//   rsp_ready  in   requester can take the response
//   rsp_rdata  out  read data, 0 for writes and for errors
//   rsp_err    out  address out of range
//   busy       out  a transaction is in flight
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH       = 32,
    parameter int AW          = 5,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        RN,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    // Any set bit above the index width means the word lies beyond the
    // array. Such addresses are flagged and never folded back onto it.
    function automatic logic addr_out_of_range(input logic [31:0] addr);
        return |addr[31:AW];
    endfunction

    // Replaces only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Transaction state and wait-state counter
    state_e          state_q,   state_d;
    logic [3:0]      cnt_q,     cnt_d;

    // Request captured on the accept edge. Only the range verdict and the
    // in-range index are kept because nothing else of the address is used.
    logic            we_q,      we_d;
    logic            oor_q,     oor_d;
    logic [AW-1:0]   idx_q,     idx_d;
    logic [31:0]     wdata_q,   wdata_d;
    logic [3:0]      wstrb_q,   wstrb_d;

    // Registered outputs
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q,   rsp_err_d;
    logic            busy_q,      busy_d;

    // Word array. It has no reset and powers up undefined.
    logic [31:0]     mem_q [DEPTH];

    logic            accept_s;
    logic            access_s;
    logic            mem_we_s;
    logic [31:0]     mem_rd_s;

    // req_ready_q is only ever high in IDLE, so it alone qualifies the accept.
    assign accept_s = req_valid & req_ready_q;
    assign access_s = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign mem_we_s = access_s & we_q & ~oor_q;
    assign mem_rd_s = mem_q[idx_q];

    // Next-state, request capture and response data computation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        oor_d       = oor_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    we_d    = req_we;
                    oor_d   = addr_out_of_range(req_addr);
                    idx_d   = req_addr[AW-1:0];
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    cnt_d   = WAIT_LOAD;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = ST_WAIT;
                end else begin
                    // Access edge: the response is captured here and then
                    // held untouched for as long as RESP is backpressured.
                    rsp_err_d = oor_q;
                    if (oor_q || we_q) begin
                        rsp_rdata_d = 32'd0;
                    end else begin
                        rsp_rdata_d = mem_rd_s;
                    end
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // Outputs are derived from the next state so that they are
        // registered and still line up with the state they describe.
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        busy_d      = (state_d != ST_IDLE);
    end

    // State, captured request and registered outputs
    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            oor_q       <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            oor_q       <= oor_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    // Array write on the access edge. While RN is low the state is held in
    // IDLE, so an abandoned write can never reach the array.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[idx_q] <= merge_bytes(mem_q[idx_q], wdata_q, wstrb_q);
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule
